alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand and result width in bits.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: valid_i  input  1  operation request.
REQ-005 SHALL have port: ready_o  output  1  block can accept; equals (state==IDLE).
REQ-006 SHALL have port: ALUCtrl_i  input  3  operation code from ALU_Control stage.
REQ-007 SHALL have port: data1_i  input  XLEN  operand A / shift source.
REQ-008 SHALL have port: data2_i  input  XLEN  operand B / shift amount in bits [log2(XLEN)-1:0].
REQ-009 SHALL have port: result_o  output  XLEN  registered result.
REQ-010 SHALL have port: zero_o  output  1  registered (result==0), used for beq.
REQ-011 SHALL have port: valid_o  output  1  one-cycle pulse marking new result_o/zero_o.

Function
REQ-012 SHALL decode ALUCtrl_i: 000 AND, 001 ADD, 010 SUB, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
REQ-013 SHALL accept an operation at edge E only when valid_i=1 and ready_o=1; valid_i with ready_o=0 ignored, no queueing.
REQ-014 SHALL latch ALUCtrl_i, data1_i, shift amount at E; input changes after E have no effect on that operation.
REQ-015 ADD/SUB SHALL wrap modulo 2^XLEN; no overflow or carry output.
REQ-016 Non-shift ops and shifts with amount 0 SHALL update result_o, zero_o and pulse valid_o at edge E (latency 1), state stays IDLE.
REQ-017 States SHALL be IDLE and SHIFT; IDLE->SHIFT on accepted shift with amount k>0; SHIFT->IDLE when remaining count reaches 0.
REQ-018 In SHIFT, each edge SHALL shift the working register by one bit and decrement count; SLL/SRL fill 0, SRA fills data1_i[XLEN-1] captured at E.
REQ-019 Shift with amount k>0 SHALL assert valid_o at edge E+k with final result; ready_o low from E through E+k, high after E+k; next accept earliest E+k+1.
REQ-020 valid_o SHALL be high for exactly one cycle per accepted operation; no backpressure from downstream.
REQ-021 result_o and zero_o SHALL hold their last value while valid_o=0, including during SHIFT (intermediate shift values not visible).
REQ-022 zero_o SHALL always equal (result_o==0) whenever valid_o has ever pulsed since reset.

Reset
REQ-023 rst_i low SHALL immediately force state IDLE, count 0, result_o 0, zero_o 0, valid_o 0, ready_o 1.
REQ-024 Reset during SHIFT SHALL abort the operation; no valid_o for it after release.
REQ-025 First accept after release SHALL be possible on the first rising edge with rst_i high.

Configuration
REQ-026 Macro ALU_FAST_SHIFT_EN defined: SLL/SRL/SRA SHALL complete as barrel shifts with latency 1 per REQ-016, SHIFT state never entered, ready_o constantly 1 outside reset.
REQ-027 Macro ALU_FAST_SHIFT_EN undefined: shifts SHALL use the serial behaviour of REQ-017 to REQ-019.

Verification
REQ-028 ADD 0xFFFFFFFF+0x00000001, valid_i 1 cycle -> next cycle result_o=0, zero_o=1, valid_o pulse width 1.
REQ-029 SUB 5-5 then AND 0xF0F0F0F0&0x0FF00FF0 back-to-back -> results 0 (zero_o=1) then 0x00F000F0 (zero_o=0) on consecutive cycles.
REQ-030 SRA 0x80000000 by 4 (serial) -> ready_o low 4 cycles, valid_o at E+4, result_o=0xF8000000; valid_i pulses during busy ignored.
REQ-031 SLL 0x1 by 0 -> latency 1, result_o=0x1, ready_o never drops; SRL 0x80000000 by 31 -> valid_o at E+31, result_o=0x1.
REQ-032 Start SLL by 20, assert rst_i low at E+5 -> outputs zero immediately, no valid_o after release; following ADD 2+3 yields 5.
REQ-033 With ALU_FAST_SHIFT_EN: SRA 0x80000000 by 4 -> result_o=0xF8000000 at latency 1, ready_o stays 1.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, shifts either serial (one bit per cycle)
// or, with ALU_FAST_SHIFT_EN defined, single-cycle barrel shifts.
module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            valid_o
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e          state_q, state_d;
    logic [SHW-1:0]  count_q, count_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [2:0]      op_q, op_d;
    logic            zero_q, zero_d;
    logic            valid_q, valid_d;
    logic            accept, serial_start, last_step;
    logic [SHW-1:0]  shamt;

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
`endif
        case (op)
            3'b000:  alu_op = a & b;
            3'b001:  alu_op = a + b;
            3'b010:  alu_op = a - b;
            3'b011:  alu_op = a | b;
            3'b100:  alu_op = a ^ b;
`ifdef ALU_FAST_SHIFT_EN
            3'b101:  alu_op = a << sh;
            3'b110:  alu_op = a >> sh;
            default: alu_op = $signed(a) >>> sh;
`else
            // only zero-amount shifts take the single-cycle path here
            default: alu_op = a;
`endif
        endcase
    endfunction

    // SRA keeps replicating the MSB, which is the sign bit captured at accept
    function automatic logic [XLEN-1:0] shift1(input logic [2:0] op, input logic [XLEN-1:0] w);
        case (op)
            3'b101:  shift1 = {w[XLEN-2:0], 1'b0};
            3'b110:  shift1 = {1'b0, w[XLEN-1:1]};
            default: shift1 = {w[XLEN-1], w[XLEN-1:1]};
        endcase
    endfunction

    assign shamt     = data2_i[SHW-1:0];
    assign accept    = valid_i && (state_q == IDLE);
    assign last_step = (state_q == SHIFT) && (count_q == SHW'(1));
`ifdef ALU_FAST_SHIFT_EN
    assign serial_start = 1'b0;
`else
    assign serial_start = accept && ALUCtrl_i[2] && (ALUCtrl_i[1:0] != 2'b00) && (shamt != '0);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        work_q <= work_d;
        op_q   <= op_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (serial_start) state_d = SHIFT;
            SHIFT:   if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        count_d  = count_q;
        work_d   = work_q;
        op_d     = op_q;
        if (state_q == SHIFT) begin
            work_d  = shift1(op_q, work_q);
            count_d = count_q - SHW'(1);
            if (last_step) begin
                result_d = work_d;
                valid_d  = 1'b1;
            end
        end else if (accept) begin
            if (serial_start) begin
                work_d  = data1_i;
                count_d = shamt;
                op_d    = ALUCtrl_i;
            end else begin
                result_d = alu_op(ALUCtrl_i, data1_i, data2_i);
                valid_d  = 1'b1;
            end
        end
        zero_d = (result_d == '0);
    end

    always_comb begin
        ready_o  = (state_q == IDLE);
        result_o = result_q;
        zero_o   = zero_q;
        valid_o  = valid_q;
    end

endmodule
